// File: rtl/gpio_cmd_writer.sv
// Config-register GPIO bus transmitter: buffers (addr, data, sw) commands in a
// FIFO and plays each one out with a setup / w_clk strobe / hold sequence.
module gpio_cmd_writer #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned STROBE_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_addr,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_sw,
  output logic [31:0]              gpio_out,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic [15:0]              writes_done
);

  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned TW    = 16;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                     state, state_next;
  logic [TW-1:0]              cnt, cnt_next;
  logic [24:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count_next;
  logic                       push, pop, strobe_done, wclk_next;
  logic                       sw_q, wclk_q;
  logic [7:0]                 data_q;
  logic [15:0]                addr_q;

  assign cmd_ready = (fifo_count < CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign gpio_out  = {6'b0, sw_q, wclk_q, data_q, addr_q};

  // Each phase counter is loaded with its length and expires when it reads 1,
  // so a phase occupies exactly that many cycles.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pop         = 1'b0;
    strobe_done = 1'b0;
    wclk_next   = wclk_q;
    case (state)
      IDLE: begin
        wclk_next = 1'b0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          cnt_next   = TW'(SETUP_CYCLES);
          state_next = SETUP;
        end
      end
      SETUP: begin
        wclk_next = 1'b0;
        if (cnt == TW'(1)) begin
          wclk_next  = 1'b1;
          cnt_next   = TW'(STROBE_CYCLES);
          state_next = STROBE;
        end else begin
          cnt_next = cnt - TW'(1);
        end
      end
      STROBE: begin
        wclk_next = 1'b1;
        if (cnt == TW'(1)) begin
          wclk_next   = 1'b0;
          strobe_done = 1'b1;
          cnt_next    = TW'(HOLD_CYCLES);
          state_next  = HOLD;
        end else begin
          cnt_next = cnt - TW'(1);
        end
      end
      HOLD: begin
        wclk_next = 1'b0;
        if (cnt == TW'(1)) begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            cnt_next   = TW'(SETUP_CYCLES);
            state_next = SETUP;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - TW'(1);
        end
      end
      default: begin
        wclk_next  = 1'b0;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    count_next = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_sw, cmd_data, cmd_addr};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      sw_q        <= 1'b0;
      wclk_q      <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      writes_done <= '0;
      busy        <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      fifo_count <= count_next;
      wclk_q     <= wclk_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                   <= rd_ptr + 1'b1;
        {sw_q, data_q, addr_q}   <= mem[rd_ptr];
      end
      writes_done <= writes_done + 16'(strobe_done);
      busy        <= (count_next != '0) || (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_gpio_cmd_writer.sv
// Bench for gpio_cmd_writer: a queue-and-timeline model of the bus checked on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_gpio_cmd_writer;

  localparam int unsigned LOG2  = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned S     = 2;
  localparam int unsigned T     = 2;
  localparam int unsigned H     = 2;
  localparam int unsigned P     = S + T + H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_sw = 1'b0;
  logic [31:0] gpio_out;
  logic        busy;
  logic [4:0]  fifo_count;
  logic [15:0] writes_done;

  gpio_cmd_writer #(
    .FIFO_DEPTH_LOG2(LOG2),
    .SETUP_CYCLES   (S),
    .STROBE_CYCLES  (T),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_sw     (cmd_sw),
    .gpio_out   (gpio_out),
    .busy       (busy),
    .fifo_count (fifo_count),
    .writes_done(writes_done)
  );

  initial forever #5 clk = ~clk;

  // Model: pending queue plus the command on the bus and how far into its
  // SETUP+STROBE+HOLD window we are.
  logic [24:0] q[$];
  logic [24:0] cur = '0;
  bit          active = 1'b0;
  int unsigned k = 0;
  logic [15:0] m_wd = '0;
  bit          preload_req = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_gpio();
    bit w;
    w = active && (k >= S) && (k < S + T);
    return {6'b0, cur[24], w, cur[23:0]};
  endfunction

  task automatic model_step();
    int unsigned pre;
    bit take;
    if (!rst) begin
      q.delete();
      cur = '0; active = 1'b0; k = 0; m_wd = '0;
    end else begin
      pre  = q.size();
      take = (!active || k == P - 1) && pre > 0;
      if (preload_req) m_wd = 16'hFFFF;
      else if (active && k == S + T - 1) m_wd = m_wd + 16'd1;
      if (take) begin
        cur = q.pop_front(); active = 1'b1; k = 0;
      end else if (active) begin
        if (k == P - 1) active = 1'b0;
        else k++;
      end
      if (cmd_valid && pre < DEPTH) q.push_back({cmd_sw, cmd_data, cmd_addr});
    end
  endtask

  task automatic compare();
    check("gpio_out", gpio_out, model_gpio());
    check("fifo_count", 32'(fifo_count), q.size());
    check("busy", 32'(busy), 32'((q.size() > 0) || active));
    check("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
    check("writes_done", 32'(writes_done), 32'(m_wd));
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push_one(input logic [15:0] a, input logic [7:0] d, input logic s);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_sw = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_strobe(input int limit);
    for (int i = 0; i < limit && !gpio_out[24]; i++) tick();
    check("strobe_timeout", 32'(gpio_out[24]), 32'd1);
  endtask

  logic [31:0] exp_single [6];
  int          rise_t [$];
  logic [15:0] rise_a [$];
  logic [15:0] wd0;
  int          acc;
  bit          full_seen;
  bit          prev_w;

  initial begin
    exp_single = '{32'h00A50003, 32'h00A50003, 32'h01A50003,
                   32'h01A50003, 32'h00A50003, 32'h00A50003};

    // Reset without comparing: outputs are unknown before the first edge.
    rst = 1'b0;
    repeat (2) begin @(posedge clk); model_step(); #1; end
    rst = 1'b1;
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_wd", 32'(writes_done), 32'd0);

    // Single write with default timing.
    push_one(16'h0003, 8'hA5, 1'b0);
    check("single_count", 32'(fifo_count), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("single_seq", gpio_out, exp_single[i]);
    end
    tick();
    check("single_wd", 32'(writes_done), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Back-to-back: pulses must be exactly one period apart.
    wd0 = writes_done;
    for (int i = 0; i < 3; i++) push_one(16'h000C + 16'(i), 8'(8'h11 * (i + 1)), 1'b0);
    prev_w = gpio_out[24];
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gpio_out[24] && !prev_w) begin
        rise_t.push_back(i);
        rise_a.push_back(gpio_out[15:0]);
      end
      prev_w = gpio_out[24];
    end
    check("b2b_pulses", rise_t.size(), 32'd3);
    if (rise_t.size() == 3) begin
      check("b2b_gap1", rise_t[1] - rise_t[0], 32'd6);
      check("b2b_gap2", rise_t[2] - rise_t[1], 32'd6);
      for (int j = 0; j < 3; j++) check("b2b_addr", 32'(rise_a[j]), 32'h000C + j);
    end
    drain(50);
    check("b2b_wd", 32'(writes_done - wd0), 32'd3);

    // Backpressure: valid held high for 40 cycles.
    wd0 = writes_done; acc = 0; full_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cmd_valid = 1'b1; cmd_addr = 16'h0100 + 16'(i); cmd_data = 8'(i); cmd_sw = i[0];
      if (cmd_ready) acc++;
      tick();
      if (fifo_count == 5'd16 && !cmd_ready) full_seen = 1'b1;
    end
    cmd_valid = 1'b0;
    check("bp_full_seen", 32'(full_seen), 32'd1);
    drain(300);
    check("bp_wd", 32'(writes_done - wd0), acc);

    // instr_b_sw set.
    push_one(16'h0000, 8'h01, 1'b1);
    wait_strobe(20);
    check("sw_strobe_word", gpio_out, 32'h03010000);
    drain(20);
    check("sw_hold_word", gpio_out, 32'h02010000);

    // Counter wrap via a forced preload of the completed-write count.
    preload_req = 1'b1;
    @(negedge clk);
    compare();
    force dut.writes_done = 16'hFFFF;
    @(posedge clk);
    model_step();
    #1;
    release dut.writes_done;
    preload_req = 1'b0;
    check("wrap_preload", 32'(writes_done), 32'h0000FFFF);
    push_one(16'h1234, 8'h56, 1'b0);
    drain(20);
    check("wrap_wd", 32'(writes_done), 32'h0);

    // Reset in the middle of a strobe with commands still queued.
    for (int i = 0; i < 5; i++) push_one(16'h0200 + 16'(i), 8'hC0 + 8'(i), 1'b0);
    wait_strobe(20);
    check("mid_queued", 32'(fifo_count), 32'd4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_gpio", gpio_out, 32'h0);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_wd", 32'(writes_done), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    push_one(16'h0ABC, 8'h7E, 1'b0);
    drain(20);
    check("mid_after_wd", 32'(writes_done), 32'd1);
    check("mid_after_gpio", gpio_out, 32'h007E0ABC);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 40);
      cmd_addr  = 16'($urandom());
      cmd_data  = 8'($urandom());
      cmd_sw    = 1'($urandom());
      rst       = ($urandom_range(0, 299) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
